// File: rtl/exec_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer_if
// Brief    : Fetch-side handshake and shared-bus control bundle for the
//            execute sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface exec_sequencer_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4
);
  logic                  ir_valid;
  logic [DATA_W-1:0]     instr;
  logic                  mfc;
  logic                  exec_done;
  logic [REG_ADDR_W-1:0] reg_sel;
  logic                  reg_out_en;
  logic                  reg_load;
  logic                  alu_a_load;
  logic                  alu_b_load;
  logic [1:0]            alu_op;
  logic                  alu_out_en;
  logic                  mar_load;
  logic                  mdr_read_en;
  logic                  mdr_out_en;
  logic                  mdr_write_en;
  logic                  mem_en;
  logic                  r_w;
  logic                  halted;
  logic                  illegal;
  logic                  bus_err;

  modport master (
    output ir_valid, instr, mfc,
    input  exec_done, reg_sel, reg_out_en, reg_load, alu_a_load, alu_b_load,
           alu_op, alu_out_en, mar_load, mdr_read_en, mdr_out_en,
           mdr_write_en, mem_en, r_w, halted, illegal, bus_err
  );

  modport slave (
    input  ir_valid, instr, mfc,
    output exec_done, reg_sel, reg_out_en, reg_load, alu_a_load, alu_b_load,
           alu_op, alu_out_en, mar_load, mdr_read_en, mdr_out_en,
           mdr_write_en, mem_en, r_w, halted, illegal, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Brief    : Execute-stage control FSM; decodes one instruction at a time and
//            sequences register file, ALU, MAR/MDR and memory strobes.
// Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
  parameter int DATA_W      = 16,
  parameter int REG_ADDR_W  = 4,
  parameter int MFC_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  exec_sequencer_if.slave bus
);

  localparam int c_CNT_W = $clog2(MFC_TIMEOUT + 1);

  localparam logic [3:0] c_IDLE    = 4'd0;
  localparam logic [3:0] c_DEC     = 4'd1;
  localparam logic [3:0] c_ALU_A   = 4'd2;
  localparam logic [3:0] c_ALU_B   = 4'd3;
  localparam logic [3:0] c_ALU_W   = 4'd4;
  localparam logic [3:0] c_MOV_W   = 4'd5;
  localparam logic [3:0] c_MOV_L   = 4'd6;
  localparam logic [3:0] c_LD_ADDR = 4'd7;
  localparam logic [3:0] c_LD_MEM  = 4'd8;
  localparam logic [3:0] c_LD_MDR  = 4'd9;
  localparam logic [3:0] c_LD_WB   = 4'd10;
  localparam logic [3:0] c_ST_ADDR = 4'd11;
  localparam logic [3:0] c_ST_DATA = 4'd12;
  localparam logic [3:0] c_ST_MEM  = 4'd13;
  localparam logic [3:0] c_DONE    = 4'd14;
  localparam logic [3:0] c_HLT     = 4'd15;

  logic [3:0]            r_state;
  logic [3:0]            w_next;
  logic [DATA_W-1:0]     r_instr;
  logic [c_CNT_W-1:0]    r_waitCnt;
  logic                  r_halted;
  logic                  r_illegal;
  logic                  r_busErr;

  logic [3:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic [1:0]            w_aluOp;
  logic                  w_inMem;
  logic                  w_timeout;

  assign w_opcode = r_instr[15:12];
  assign w_rd     = r_instr[8 +: REG_ADDR_W];
  assign w_rs     = r_instr[4 +: REG_ADDR_W];
  assign w_rt     = r_instr[0 +: REG_ADDR_W];
  // Opcodes 1..4 map onto ALU codes 0..3; the wrap of 4 to 3 is intended.
  assign w_aluOp  = w_opcode[1:0] - 2'd1;

  assign w_inMem   = (r_state == c_LD_MEM) || (r_state == c_ST_MEM);
  assign w_timeout = w_inMem && !bus.mfc &&
                     (r_waitCnt == c_CNT_W'(MFC_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (bus.ir_valid) w_next = c_DEC;
      c_DEC: begin
        case (w_opcode)
          4'h1, 4'h2, 4'h3, 4'h4: w_next = c_ALU_A;
          4'h5:                   w_next = c_LD_ADDR;
          4'h6:                   w_next = c_ST_ADDR;
          4'h7:                   w_next = c_MOV_W;
          4'hF:                   w_next = c_HLT;
          default:                w_next = c_DONE;
        endcase
      end
      c_ALU_A:   w_next = c_ALU_B;
      c_ALU_B:   w_next = c_ALU_W;
      c_ALU_W:   w_next = c_DONE;
      c_MOV_W:   w_next = c_MOV_L;
      c_MOV_L:   w_next = c_DONE;
      c_LD_ADDR: w_next = c_LD_MEM;
      c_LD_MEM: begin
        if (bus.mfc)       w_next = c_LD_MDR;
        else if (w_timeout) w_next = c_DONE;
      end
      c_LD_MDR:  w_next = c_LD_WB;
      c_LD_WB:   w_next = c_DONE;
      c_ST_ADDR: w_next = c_ST_DATA;
      c_ST_DATA: w_next = c_ST_MEM;
      c_ST_MEM:  if (bus.mfc || w_timeout) w_next = c_DONE;
      c_DONE:    w_next = c_IDLE;
      c_HLT:     w_next = c_HLT;
      default:   w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_instr   <= '0;
      r_waitCnt <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == c_IDLE) && bus.ir_valid) r_instr <= bus.instr;
      if (!w_inMem)      r_waitCnt <= '0;
      else if (!bus.mfc) r_waitCnt <= r_waitCnt + c_CNT_W'(1);
      if ((r_state == c_DEC) && (w_opcode >= 4'h8) && (w_opcode <= 4'hE))
        r_illegal <= 1'b1;
      if ((r_state == c_DEC) && (w_opcode == 4'hF)) r_halted <= 1'b1;
      if (w_timeout) r_busErr <= 1'b1;
    end
  end

  always_comb begin
    bus.exec_done    = 1'b0;
    bus.reg_sel      = '0;
    bus.reg_out_en   = 1'b0;
    bus.reg_load     = 1'b0;
    bus.alu_a_load   = 1'b0;
    bus.alu_b_load   = 1'b0;
    bus.alu_op       = 2'b00;
    bus.alu_out_en   = 1'b0;
    bus.mar_load     = 1'b0;
    bus.mdr_read_en  = 1'b0;
    bus.mdr_out_en   = 1'b0;
    bus.mdr_write_en = 1'b0;
    bus.mem_en       = 1'b0;
    case (r_state)
      c_ALU_A: begin
        bus.reg_sel = w_rs; bus.reg_out_en = 1'b1; bus.alu_a_load = 1'b1;
        bus.alu_op  = w_aluOp;
      end
      c_ALU_B: begin
        bus.reg_sel = w_rt; bus.reg_out_en = 1'b1; bus.alu_b_load = 1'b1;
        bus.alu_op  = w_aluOp;
      end
      c_ALU_W: begin
        bus.reg_sel = w_rd; bus.alu_out_en = 1'b1; bus.reg_load = 1'b1;
        bus.alu_op  = w_aluOp;
      end
      c_MOV_W: begin
        bus.reg_sel = w_rs; bus.reg_out_en = 1'b1;
      end
      // The bus keeper holds the rs value while rd loads.
      c_MOV_L: begin
        bus.reg_sel = w_rd; bus.reg_load = 1'b1;
      end
      c_LD_ADDR, c_ST_ADDR: begin
        bus.reg_sel = w_rs; bus.reg_out_en = 1'b1; bus.mar_load = 1'b1;
      end
      c_LD_MEM, c_ST_MEM: bus.mem_en = 1'b1;
      c_LD_MDR: bus.mdr_read_en = 1'b1;
      c_LD_WB: begin
        bus.reg_sel = w_rd; bus.mdr_out_en = 1'b1; bus.reg_load = 1'b1;
      end
      c_ST_DATA: begin
        bus.reg_sel = w_rd; bus.reg_out_en = 1'b1; bus.mdr_write_en = 1'b1;
      end
      c_DONE: bus.exec_done = 1'b1;
      default: ;
    endcase
  end

  // r_w idles at read, but is forced low while reset is held.
  assign bus.r_w     = !reset && (r_state != c_ST_MEM);
  assign bus.halted  = r_halted;
  assign bus.illegal = r_illegal;
  assign bus.bus_err = r_busErr;

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Execute-stage control FSM directly downstream of the instruction-fetch sequencer.
- Captures the 16-bit instruction word when fetch signals IR-loaded, decodes it, and sequences shared-bus control signals: register file, ALU operand latches, MAR, MDR, memory.
- Pulses exec_done to let fetch begin the next cycle.
- One instruction in flight; no pipelining.

Parameters:
- DATA_W, 16, instruction/bus width.
- REG_ADDR_W, 4, register-select width (16 registers).
- MFC_TIMEOUT, 15, max cycles waiting for MFC before bus error.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ir_valid  in  1  one-cycle pulse from fetch: instruction register holds a new word.
- instr  in  DATA_W  instruction word. Fields: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
- mfc  in  1  memory function complete.
- exec_done  out  1  one-cycle pulse: instruction retired, fetch may restart.
- reg_sel  out  REG_ADDR_W  register index for bus read/write.
- reg_out_en  out  1  selected register drives bus.
- reg_load  out  1  selected register loads from bus.
- alu_a_load  out  1  ALU operand A latch loads from bus.
- alu_b_load  out  1  ALU operand B latch loads from bus.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- alu_out_en  out  1  ALU result drives bus.
- mar_load  out  1  MAR loads from bus.
- mdr_read_en  out  1  MDR captures memory data.
- mdr_out_en  out  1  MDR drives bus.
- mdr_write_en  out  1  MDR loads from bus (store path).
- mem_en  out  1  memory access enable.
- r_w  out  1  1 = read, 0 = write.
- halted  out  1  sticky; HALT executed.
- illegal  out  1  sticky; undefined opcode seen.
- bus_err  out  1  sticky; MFC timeout.

Behaviour:
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd <- rs op rt
  - 5 LOAD: rd <- mem[rs]
  - 6 STORE: mem[rs] <- rd
  - 7 MOV: rd <- rs
  - F HALT
  - 8–E illegal: set illegal, execute as NOP.
- Reset (async): state IDLE; all outputs 0; reg_sel 0; alu_op 0; sticky flags cleared; instr latch cleared; timeout counter 0.
- State is registered. All outputs are Moore functions of the registered state and the latched instruction, except the sticky flags, which are registered.
- IDLE: on ir_valid, latch instr, go to DEC. ir_valid is ignored in every other state and in HALT.
- DEC: no bus activity; one cycle. Branches by opcode:
  - ALU ops -> ALU_A
  - MOV -> MOV_W
  - LOAD -> LD_ADDR
  - STORE -> ST_ADDR
  - NOP/illegal -> DONE
  - HALT -> HLT
- ALU_A: reg_sel=rs, reg_out_en, alu_a_load.
- ALU_B: reg_sel=rt, reg_out_en, alu_b_load.
- ALU_W: alu_out_en, reg_sel=rd, reg_load, alu_op held valid -> DONE. alu_op is driven for the whole ALU_A..ALU_W sequence.
- MOV_W: reg_sel=rs, reg_out_en -> MOV_L: alu-free, rd loads from bus with reg_sel=rd, reg_load. rs drive is dropped; bus hold is guaranteed by the bus keeper. Then DONE.
- LD_ADDR: reg_sel=rs, reg_out_en, mar_load.
- LD_MEM: mem_en, r_w=1; wait for mfc.
- LD_MDR: mdr_read_en.
- LD_WB: mdr_out_en, reg_sel=rd, reg_load -> DONE.
- ST_ADDR: reg_sel=rs, reg_out_en, mar_load.
- ST_DATA: reg_sel=rd, reg_out_en, mdr_write_en.
- ST_MEM: mem_en, r_w=0; wait for mfc -> DONE.
- MFC wait (LD_MEM, ST_MEM):
  - Counter clears on state entry and increments each cycle mfc=0.
  - mfc=1 sampled -> next state.
  - Counter reaching MFC_TIMEOUT with mfc=0 -> set bus_err, drop mem_en, go to DONE. No register write-back occurs on a load timeout.
- DONE: exec_done=1 for exactly one cycle -> IDLE.
- HLT: halted=1. Terminal; only reset exits. exec_done is never pulsed.
- r_w is 1 in all states except ST_MEM. The strobes listed per state are the only ones asserted. No two bus drivers (reg_out_en, alu_out_en, mdr_out_en) are ever high in the same cycle.
- Latency from the ir_valid cycle (T0) to the exec_done cycle:
  - NOP 2
  - ALU 5
  - MOV 4
  - LOAD 6+w
  - STORE 5+w
  - w = extra cycles until mfc (w = 0 if mfc high on first MEM cycle).
- Reset mid-instruction aborts immediately: all strobes drop in the same cycle, no exec_done.

Test Plan:
- ADD: instr=0x1123 pulsed at T0 -> T2 reg_sel=2/reg_out_en/alu_a_load; T3 reg_sel=3/alu_b_load; T4 alu_out_en/reg_sel=1/reg_load, alu_op=00; T5 exec_done; T6 idle.
- LOAD: instr=0x5450, mfc high 2 cycles after LD_MEM entry -> mar_load with reg_sel=5; mem_en/r_w=1 for 3 cycles; mdr_read_en; mdr_out_en+reg_load reg_sel=4; exec_done at T8.
- STORE: instr=0x6730, mfc immediate -> mar_load (rs=3), mdr_write_en (rd=7), mem_en with r_w=0 one cycle, exec_done at T5.
- Timeout: LOAD with mfc held 0 -> mem_en for MFC_TIMEOUT cycles, bus_err=1, no reg_load, exec_done once; then a NOP still completes and bus_err stays 1.
- HALT: instr=0xF000 -> halted=1 from T2; further ir_valid pulses produce no strobes and no exec_done until reset. Opcode 0x9 -> illegal=1, exec_done at T2.
- Async reset asserted during ALU_B -> all outputs 0 immediately; after release, ir_valid with 0x2456 executes normally with alu_op=01.
